weight_buffer_ctrl: RTL and testbench

Sequencer directly upstream of the weight buffer banks. Accepts weight rows from the DMA stream over a valid/ready handshake and writes them into the buffer. Each row carries one buffer_width word per PE column. On command it reads nb_taps consecutive rows out and steers each one into a tap register through one-hot weight_load_en. It owns all address, enable and n_ap generation for the buffer array.

---
 rtl/weight_buffer_pkg.sv | 30 +++
 rtl/weight_buffer_ctrl_if.sv | 15 +
 rtl/weight_buffer_ctrl_rd_pipe.sv | 37 +++
 rtl/weight_buffer_ctrl.sv | 177 +++++++++++++++++
 tb/tb_weight_buffer_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_buffer_pkg.sv
// Shared constants, FSM state type and address-width helper for the weight buffer
// controller and the bank array it drives.
package weight_buffer_pkg;

  localparam int default_nb_pe_col    = 32;
  localparam int default_nb_taps      = 5;
  localparam int default_buffer_width = 16;
  localparam int default_buffer_depth = 72;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Bits needed to address `value` entries; returns 0 for value <= 1.
  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/weight_buffer_ctrl_if.sv
// Weight-row stream from the DMA into the buffer controller.
interface weight_buffer_ctrl_if
  import weight_buffer_pkg::*;
#(
  parameter int data_width = default_nb_pe_col * default_buffer_width
);
  // A row transfers on every rising edge where wt_in_valid && wt_in_ready; the
  // master holds data stable while valid is high and not yet accepted.
  logic [data_width-1:0] wt_in_data;
  logic                  wt_in_valid;
  logic                  wt_in_ready;

  modport master (output wt_in_data, output wt_in_valid, input wt_in_ready);
  modport slave  (input wt_in_data, input wt_in_valid, output wt_in_ready);
endinterface

// File: rtl/weight_buffer_ctrl_rd_pipe.sv
// Delay line matching buffer read latency: carries the one-hot tap enable and the
// final-tap flag so tap capture lines up with read data.
module weight_buffer_ctrl_rd_pipe #(
  parameter int nb_taps    = 5,
  parameter int rd_latency = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [nb_taps-1:0] tap_in,
  input  logic               last_in,
  output logic [nb_taps-1:0] tap_out,
  output logic               last_out
);

  logic [nb_taps-1:0] tap_sr [rd_latency];
  logic               last_sr[rd_latency];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < rd_latency; i++) begin
        tap_sr[i]  <= '0;
        last_sr[i] <= 1'b0;
      end
    end else begin
      tap_sr[0]  <= tap_in;
      last_sr[0] <= last_in;
      for (int i = 1; i < rd_latency; i++) begin
        tap_sr[i]  <= tap_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign tap_out  = tap_sr[rd_latency-1];
  assign last_out = last_sr[rd_latency-1];

endmodule

// File: rtl/weight_buffer_ctrl.sv
// Weight buffer sequencer: writes DMA rows into the banks (FILL) and reads nb_taps
// consecutive rows into the tap registers (LOAD/DRAIN).
module weight_buffer_ctrl
  import weight_buffer_pkg::*;
#(
  parameter int nb_pe_col         = default_nb_pe_col,
  parameter int nb_taps           = default_nb_taps,
  parameter int buffer_width      = default_buffer_width,
  parameter int buffer_depth      = default_buffer_depth,
  parameter int buffer_addr_width = clogb2(buffer_depth),
  parameter int rd_latency        = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  weight_buffer_ctrl_if.slave               wt_in,
  input  logic                              fill_start,
  input  logic [buffer_addr_width-1:0]      fill_base,
  input  logic [buffer_addr_width:0]        fill_len,
  input  logic                              load_start,
  input  logic [buffer_addr_width-1:0]      load_base,
  input  logic [3:0]                        n_ap_cfg,
  output logic [nb_pe_col*buffer_width-1:0] buffer_data_in,
  output logic [buffer_addr_width-1:0]      wAddr,
  output logic                              buffer_wEn,
  output logic [buffer_addr_width-1:0]      rAddr,
  output logic                              buffer_rEn,
  output logic [nb_taps-1:0]                weight_load_en,
  output logic [3:0]                        n_ap,
  output logic                              busy,
  output logic                              fill_done,
  output logic                              load_done,
  output logic                              load_err,
  output state_t                            state_dbg
);

  localparam int aw = buffer_addr_width;
  localparam int kw = (nb_taps > 1) ? clogb2(nb_taps) : 1;
  localparam logic [aw-1:0]      last_row  = aw'(buffer_depth - 1);
  localparam logic [aw:0]        depth_ext = (aw+1)'(buffer_depth);
  localparam logic [aw:0]        cnt_one   = (aw+1)'(1);
  localparam logic [kw-1:0]      last_k    = kw'(nb_taps - 1);
  localparam logic [nb_taps-1:0] tap_one   = nb_taps'(1);

  state_t state, state_n;
  logic [aw-1:0] wr_ptr, wr_ptr_n;
  logic [aw:0]   cnt, cnt_n;
  logic [kw-1:0] k, k_n;
  logic [aw-1:0] wAddr_n, rAddr_n;
  logic [nb_pe_col*buffer_width-1:0] data_n;
  logic          wEn_n, rEn_n, fill_done_n, load_err_n;
  logic [3:0]    n_ap_n;
  logic          fill_rdy;
  logic [nb_taps-1:0] tap_in;
  logic          last_in, last_out;

  function automatic logic [aw-1:0] next_row(input logic [aw-1:0] a);
    return (a == last_row) ? '0 : a + 1'b1;
  endfunction

  assign fill_rdy          = (state == FILL);
  assign wt_in.wt_in_ready = fill_rdy;
  assign busy              = (state != IDLE);
  assign state_dbg         = state;

  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    cnt_n       = cnt;
    k_n         = k;
    wAddr_n     = wAddr;
    data_n      = buffer_data_in;
    wEn_n       = 1'b0;
    rAddr_n     = rAddr;
    rEn_n       = 1'b0;
    n_ap_n      = n_ap;
    fill_done_n = 1'b0;
    load_err_n  = 1'b0;
    case (state)
      IDLE: begin
        // Fill has priority; a load arriving in the same cycle is dropped.
        if (fill_start) begin
          if (fill_len == '0) begin
            fill_done_n = 1'b1;
          end else begin
            state_n  = FILL;
            wr_ptr_n = fill_base;
            cnt_n    = fill_len;
          end
        end else if (load_start) begin
          if ({1'b0, load_base} >= depth_ext) begin
            load_err_n = 1'b1;
          end else begin
            state_n = LOAD;
            rEn_n   = 1'b1;
            rAddr_n = load_base;
            k_n     = '0;
            n_ap_n  = n_ap_cfg;
          end
        end
      end
      FILL: begin
        if (wt_in.wt_in_valid && fill_rdy) begin
          wEn_n    = 1'b1;
          wAddr_n  = wr_ptr;
          data_n   = wt_in.wt_in_data;
          wr_ptr_n = next_row(wr_ptr);
          cnt_n    = cnt - 1'b1;
          if (cnt == cnt_one) begin
            state_n     = IDLE;
            fill_done_n = 1'b1;
          end
        end
      end
      LOAD: begin
        // k is the tap index of the read currently on rAddr.
        if (k == last_k) begin
          state_n = DRAIN;
        end else begin
          rEn_n   = 1'b1;
          rAddr_n = next_row(rAddr);
          k_n     = k + 1'b1;
        end
      end
      DRAIN: begin
        if (last_out) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      cnt            <= '0;
      k              <= '0;
      wAddr          <= '0;
      buffer_data_in <= '0;
      buffer_wEn     <= 1'b0;
      rAddr          <= '0;
      buffer_rEn     <= 1'b0;
      n_ap           <= '0;
      fill_done      <= 1'b0;
      load_err       <= 1'b0;
    end else begin
      state          <= state_n;
      wr_ptr         <= wr_ptr_n;
      cnt            <= cnt_n;
      k              <= k_n;
      wAddr          <= wAddr_n;
      buffer_data_in <= data_n;
      buffer_wEn     <= wEn_n;
      rAddr          <= rAddr_n;
      buffer_rEn     <= rEn_n;
      n_ap           <= n_ap_n;
      fill_done      <= fill_done_n;
      load_err       <= load_err_n;
    end
  end

  assign tap_in  = buffer_rEn ? (tap_one << k) : '0;
  assign last_in = buffer_rEn && (k == last_k);

  weight_buffer_ctrl_rd_pipe #(
    .nb_taps    (nb_taps),
    .rd_latency (rd_latency)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .tap_in   (tap_in),
    .last_in  (last_in),
    .tap_out  (weight_load_en),
    .last_out (last_out)
  );
  assign load_done = last_out;

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Self-checking bench for weight_buffer_ctrl: directed fill/load scenarios followed
// by randomized commands, checked against an address/timing model of the controller.
module tb_weight_buffer_ctrl;
  import weight_buffer_pkg::*;

  localparam int n_col = 32;
  localparam int bw    = 16;
  localparam int dw    = n_col * bw;
  localparam int depth = 72;
  localparam int aw    = 7;
  localparam int nt    = 5;
  localparam int rl    = 1;
  localparam int cw    = 560;

  logic clk = 1'b0;
  logic rst;
  logic fill_start, load_start;
  logic [aw-1:0] fill_base, load_base;
  logic [aw:0]   fill_len;
  logic [3:0]    n_ap_cfg;
  logic [dw-1:0] buffer_data_in;
  logic [aw-1:0] wAddr, rAddr;
  logic          buffer_wEn, buffer_rEn, busy, fill_done, load_done, load_err;
  logic [nt-1:0] weight_load_en;
  logic [3:0]    n_ap;
  state_t        state_dbg;

  weight_buffer_ctrl_if #(.data_width(dw)) wt_bus ();

  weight_buffer_ctrl #(
    .nb_pe_col(n_col), .nb_taps(nt), .buffer_width(bw), .buffer_depth(depth),
    .buffer_addr_width(aw), .rd_latency(rl)
  ) dut (
    .clk(clk), .rst(rst), .wt_in(wt_bus),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .load_start(load_start), .load_base(load_base), .n_ap_cfg(n_ap_cfg),
    .buffer_data_in(buffer_data_in), .wAddr(wAddr), .buffer_wEn(buffer_wEn),
    .rAddr(rAddr), .buffer_rEn(buffer_rEn), .weight_load_en(weight_load_en),
    .n_ap(n_ap), .busy(busy), .fill_done(fill_done), .load_done(load_done),
    .load_err(load_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [cw-1:0] exp_q[$];
  logic [3:0]    exp_nap = 4'd0;

  task automatic check_eq(input string tag, input logic [cw-1:0] act, input logic [cw-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [dw-1:0] rand_row();
    logic [dw-1:0] r;
    for (int i = 0; i < dw / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [cw-1:0] all_outs();
    return {buffer_data_in, wAddr, buffer_wEn, rAddr, buffer_rEn, weight_load_en, n_ap,
            busy, fill_done, load_done, load_err, wt_bus.wt_in_ready, state_dbg};
  endfunction

  // driver + checker for one fill command; pat gives the valid pattern when rnd is 0
  task automatic do_fill(input int base, input int len, input logic [15:0] pat,
                         input bit rnd, input bit coll);
    logic [dw-1:0] rows[$];
    logic v;
    int sent, cyc;
    rows.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      rows.push_back(rand_row());
      exp_q.push_back({(aw)'((base + i) % depth), rows[i]});
    end
    fill_start = 1'b1;
    fill_base  = aw'(base);
    fill_len   = (aw+1)'(len);
    load_start = coll;
    load_base  = aw'($urandom_range(0, depth - 1));
    tick();
    fill_start = 1'b0;
    load_start = 1'b0;
    check_eq("fill_cmd_ren", buffer_rEn, 1'b0);
    if (len == 0) begin
      check_eq("fill0_done", fill_done, 1'b1);
      check_eq("fill0_wen", buffer_wEn, 1'b0);
      check_eq("fill0_busy", busy, 1'b0);
      tick();
      check_eq("fill0_done_clr", fill_done, 1'b0);
      check_eq("fill0_wen2", buffer_wEn, 1'b0);
    end else begin
      check_eq("fill_busy", busy, 1'b1);
      check_eq("fill_ready", wt_bus.wt_in_ready, 1'b1);
      sent = 0;
      cyc  = 0;
      while (sent < len && cyc < len * 4 + 8) begin
        if (rnd) v = (cyc >= len * 3) ? 1'b1 : 1'($urandom_range(0, 1));
        else     v = pat[cyc % 16];
        wt_bus.wt_in_valid = v;
        wt_bus.wt_in_data  = v ? rows[sent] : rand_row();
        load_start = coll && (cyc == 1);
        load_base  = aw'($urandom_range(0, depth - 1));
        tick();
        cyc++;
        load_start = 1'b0;
        check_eq("fill_wen", buffer_wEn, v);
        check_eq("fill_ren", buffer_rEn, 1'b0);
        if (v) begin
          sent++;
          check_eq("fill_wr", {wAddr, buffer_data_in}, exp_q.pop_front());
          check_eq("fill_done", fill_done, sent == len);
        end else begin
          check_eq("fill_done_idle", fill_done, 1'b0);
        end
        check_eq("fill_busy_run", busy, sent < len);
        check_eq("fill_ready_run", wt_bus.wt_in_ready, sent < len);
      end
      wt_bus.wt_in_valid = 1'b0;
      check_eq("fill_rows_sent", sent, len);
      tick();
      check_eq("fill_post_busy", busy, 1'b0);
      check_eq("fill_post_done", fill_done, 1'b0);
      check_eq("fill_post_wen", buffer_wEn, 1'b0);
    end
    check_eq("fill_q_empty", exp_q.size(), 0);
    check_eq("fill_nap", n_ap, exp_nap);
  endtask

  // driver + checker for one load command
  task automatic do_load(input int base, input logic [3:0] cfg);
    load_start = 1'b1;
    load_base  = aw'(base);
    n_ap_cfg   = cfg;
    tick();
    load_start = 1'b0;
    n_ap_cfg   = 4'($urandom_range(0, 15));
    if (base >= depth) begin
      check_eq("lderr_pulse", load_err, 1'b1);
      check_eq("lderr_ren", buffer_rEn, 1'b0);
      check_eq("lderr_busy", busy, 1'b0);
      check_eq("lderr_nap", n_ap, exp_nap);
      tick();
      check_eq("lderr_clr", load_err, 1'b0);
      check_eq("lderr_ren2", buffer_rEn, 1'b0);
      check_eq("lderr_nap2", n_ap, exp_nap);
    end else begin
      exp_nap = cfg;
      exp_q.delete();
      for (int j = 0; j < nt; j++) exp_q.push_back(cw'((base + j) % depth));
      for (int c = 0; c <= nt - 1 + rl; c++) begin
        check_eq("ld_ren", buffer_rEn, c < nt);
        if (c < nt) check_eq("ld_raddr", rAddr, exp_q.pop_front());
        check_eq("ld_tap", weight_load_en, (c >= rl) ? (cw'(1) << (c - rl)) : cw'(0));
        check_eq("ld_done", load_done, c == nt - 1 + rl);
        check_eq("ld_busy", busy, 1'b1);
        check_eq("ld_nap", n_ap, exp_nap);
        check_eq("ld_wen", buffer_wEn, 1'b0);
        check_eq("ld_err", load_err, 1'b0);
        tick();
      end
      check_eq("ld_post_busy", busy, 1'b0);
      check_eq("ld_post_done", load_done, 1'b0);
      check_eq("ld_post_tap", weight_load_en, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [dw-1:0] r0;
    rst = 1'b1;
    fill_start = 1'b0; load_start = 1'b0;
    fill_base = '0; load_base = '0; fill_len = '0; n_ap_cfg = '0;
    wt_bus.wt_in_valid = 1'b0;
    wt_bus.wt_in_data  = '0;
    repeat (3) tick();
    check_eq("reset_outs", all_outs(), 0);
    rst = 1'b0;
    tick();
    check_eq("idle_outs", all_outs(), 0);

    do_fill(5, 3, 16'hFFFD, 1'b0, 1'b0);   // valid 1,0,1,1
    do_fill(70, 4, 16'hFFFF, 1'b0, 1'b0);  // write wrap
    do_load(10, 4'd6);
    do_load(70, 4'd9);                     // read wrap
    do_load(72, 4'd3);                     // out of range
    do_fill(40, 2, 16'hFFFF, 1'b0, 1'b1);  // collisions
    do_fill(12, 0, 16'hFFFF, 1'b0, 1'b1);  // zero length with collision

    // asynchronous reset in the middle of a 4-row fill
    fill_start = 1'b1; fill_base = 7'd20; fill_len = 8'd4;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r0 = rand_row();
      wt_bus.wt_in_valid = 1'b1;
      wt_bus.wt_in_data  = r0;
      tick();
      check_eq("rst_pre_wr", {buffer_wEn, wAddr, buffer_data_in}, {1'b1, 7'(20 + i), r0});
    end
    #2 rst = 1'b1;
    #1 check_eq("rst_async_outs", all_outs(), 0);
    wt_bus.wt_in_valid = 1'b0;
    exp_nap = 4'd0;
    repeat (2) begin
      tick();
      check_eq("rst_hold_outs", all_outs(), 0);
    end
    rst = 1'b0;
    tick();
    check_eq("rst_release_outs", all_outs(), 0);
    do_fill(30, 3, 16'hFFFF, 1'b0, 1'b0);

    // randomized command mix
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_fill($urandom_range(0, depth - 1), (i == 7) ? depth : $urandom_range(0, 10),
                16'hFFFF, 1'b1, 1'($urandom_range(0, 1)));
      end else begin
        do_load($urandom_range(0, depth + 7), 4'($urandom_range(0, 15)));
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        check_eq("gap_busy", busy, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
